// File: rtl/hpdmc_pkg.sv
// Shared definitions for the HPDMC row controller: SDRAM command encodings
// and the row-manager FSM state set.
package hpdmc_pkg;

  typedef enum logic [1:0] {
    OP_ACT   = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_PRE   = 2'b11
  } cmd_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PRE_WAIT,
    TRP,
    ACT,
    TRCD,
    RW,
    CLOSE_WAIT
  } state_t;

  // Address bit that selects all-bank PRECHARGE.
  localparam int A10 = 10;

endpackage

// File: rtl/hpdmc_rowctl_if.sv
// Request handshake and SDRAM command bus of the row controller; the master
// side issues accesses and observes commands, the slave side is the controller.
interface hpdmc_rowctl_if #(
  parameter int ROW_W = 13,
  parameter int COL_W = 10
);
  logic             req_stb;
  logic             req_we;
  logic [1:0]       req_bank;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             req_ack;

  logic             cmd_stb;
  logic [1:0]       cmd_op;
  logic [1:0]       cmd_bank;
  logic [ROW_W-1:0] cmd_addr;
  logic [3:0]       read;
  logic [3:0]       write;

  modport master (
    output req_stb, req_we, req_bank, req_row, req_col,
    input  req_ack, cmd_stb, cmd_op, cmd_bank, cmd_addr, read, write
  );

  modport slave (
    input  req_stb, req_we, req_bank, req_row, req_col,
    output req_ack, cmd_stb, cmd_op, cmd_bank, cmd_addr, read, write
  );
endinterface

// File: rtl/hpdmc_rowctl_delay.sv
// Shared tRP/tRCD down-counter: a load of 0 behaves as 1, and done is high
// during the last counted cycle so the FSM can move on at the next edge.
module hpdmc_rowctl_delay (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] value,
  output logic       done
);
  logic [2:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 3'd0;
    end else if (load) begin
      count <= (value == 3'd0) ? 3'd1 : value;
    end else if (count != 3'd0) begin
      count <= count - 3'd1;
    end
  end

  assign done = (count <= 3'd1);

endmodule

// File: rtl/hpdmc_rowctl.sv
// Per-bank open-row tracker and PRECHARGE/ACTIVATE/READ/WRITE sequencer.
// Defining HPDMC_ROWCTL_PERF_EN adds saturating hit/miss counters.
module hpdmc_rowctl
  import hpdmc_pkg::*;
#(
  parameter int ROW_W = 13,
  parameter int COL_W = 10
) (
  input  logic        sys_clk,
  input  logic        sdram_rst_n,
  input  logic [2:0]  tim_rp,
  input  logic [2:0]  tim_rcd,
  input  logic [3:0]  precharge_safe,
  input  logic        close_all,
  output logic        close_done,
`ifdef HPDMC_ROWCTL_PERF_EN
  output logic [15:0] stat_hit,
  output logic [15:0] stat_miss,
`endif
  hpdmc_rowctl_if.slave bus
);
  state_t           state, state_n;
  logic [3:0]       open_q;
  logic [ROW_W-1:0] row_q [4];

  logic             lat_we;
  logic [1:0]       lat_bank;
  logic [ROW_W-1:0] lat_row;
  logic [COL_W-1:0] lat_col;

  logic             cur_we;
  logic [1:0]       cur_bank;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             hit;

  logic             go_pre, go_act, go_rw, go_close;
  logic             dly_load, dly_done;
  logic [2:0]       dly_value;

  logic             cmd_stb_n, ack_n, done_n;
  cmd_op_t          cmd_op_n;
  logic [1:0]       cmd_bank_n;
  logic [ROW_W-1:0] cmd_addr_n;
  logic [3:0]       read_n, write_n;

  // In IDLE the live request is used so a hit can issue on the very next cycle.
  assign cur_we   = (state == IDLE) ? bus.req_we   : lat_we;
  assign cur_bank = (state == IDLE) ? bus.req_bank : lat_bank;
  assign cur_row  = (state == IDLE) ? bus.req_row  : lat_row;
  assign cur_col  = (state == IDLE) ? bus.req_col  : lat_col;
  assign hit      = open_q[cur_bank] && (row_q[cur_bank] == cur_row);

  hpdmc_rowctl_delay u_delay (
    .clk   (sys_clk),
    .rst_n (sdram_rst_n),
    .load  (dly_load),
    .value (dly_value),
    .done  (dly_done)
  );

  always_comb begin
    state_n    = state;
    go_pre     = 1'b0;
    go_act     = 1'b0;
    go_rw      = 1'b0;
    go_close   = 1'b0;
    dly_load   = 1'b0;
    dly_value  = tim_rcd;
    cmd_stb_n  = 1'b0;
    cmd_op_n   = OP_ACT;
    cmd_bank_n = 2'd0;
    cmd_addr_n = '0;
    ack_n      = 1'b0;
    done_n     = 1'b0;
    read_n     = 4'd0;
    write_n    = 4'd0;

    case (state)
      IDLE: begin
        // close_done is still high in the first IDLE cycle after a close, so
        // a level close_all not yet dropped is not serviced twice.
        if (close_all && !close_done) begin
          state_n = CLOSE_WAIT;
        end else if (bus.req_stb) begin
          if (hit)                          go_rw   = 1'b1;
          else if (!open_q[cur_bank])       go_act  = 1'b1;
          else if (precharge_safe[cur_bank]) go_pre = 1'b1;
          else                              state_n = PRE_WAIT;
        end
      end
      PRE_WAIT: if (precharge_safe[cur_bank]) go_pre = 1'b1;
      TRP:      if (dly_done) go_act = 1'b1;
      ACT, TRCD: begin
        if (dly_done) go_rw = 1'b1;
        else          state_n = TRCD;
      end
      RW:       state_n = IDLE;
      CLOSE_WAIT: begin
        if (&(precharge_safe | ~open_q)) begin
          state_n  = IDLE;
          go_close = 1'b1;
          done_n   = 1'b1;
          if (|open_q) begin
            cmd_stb_n       = 1'b1;
            cmd_op_n        = OP_PRE;
            cmd_addr_n[A10] = 1'b1;
          end
        end
      end
      default:  state_n = IDLE;
    endcase

    if (go_pre) begin
      state_n    = TRP;
      dly_load   = 1'b1;
      dly_value  = tim_rp;
      cmd_stb_n  = 1'b1;
      cmd_op_n   = OP_PRE;
      cmd_bank_n = cur_bank;
    end
    if (go_act) begin
      state_n    = ACT;
      dly_load   = 1'b1;
      dly_value  = tim_rcd;
      cmd_stb_n  = 1'b1;
      cmd_op_n   = OP_ACT;
      cmd_bank_n = cur_bank;
      cmd_addr_n = cur_row;
    end
    if (go_rw) begin
      state_n    = RW;
      cmd_stb_n  = 1'b1;
      cmd_op_n   = cur_we ? OP_WRITE : OP_READ;
      cmd_bank_n = cur_bank;
      cmd_addr_n = ROW_W'(cur_col);
      ack_n      = 1'b1;
      read_n     = cur_we ? 4'd0 : (4'b0001 << cur_bank);
      write_n    = cur_we ? (4'b0001 << cur_bank) : 4'd0;
    end
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) state <= IDLE;
    else              state <= state_n;
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      bus.cmd_stb  <= 1'b0;
      bus.cmd_op   <= 2'd0;
      bus.cmd_bank <= 2'd0;
      bus.cmd_addr <= '0;
      bus.req_ack  <= 1'b0;
      bus.read     <= 4'd0;
      bus.write    <= 4'd0;
      close_done   <= 1'b0;
    end else begin
      bus.cmd_stb  <= cmd_stb_n;
      bus.cmd_op   <= cmd_op_n;
      bus.cmd_bank <= cmd_bank_n;
      bus.cmd_addr <= cmd_addr_n;
      bus.req_ack  <= ack_n;
      bus.read     <= read_n;
      bus.write    <= write_n;
      close_done   <= done_n;
    end
  end

  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      open_q   <= 4'd0;
      for (int b = 0; b < 4; b++) row_q[b] <= '0;
      lat_we   <= 1'b0;
      lat_bank <= 2'd0;
      lat_row  <= '0;
      lat_col  <= '0;
    end else begin
      if (state == IDLE) begin
        lat_we   <= bus.req_we;
        lat_bank <= bus.req_bank;
        lat_row  <= bus.req_row;
        lat_col  <= bus.req_col;
      end
      if (go_act) begin
        open_q[cur_bank] <= 1'b1;
        row_q[cur_bank]  <= cur_row;
      end
      if (go_pre)   open_q[cur_bank] <= 1'b0;
      if (go_close) open_q <= 4'd0;
    end
  end

`ifdef HPDMC_ROWCTL_PERF_EN
  logic lat_miss;

  // A hit acknowledges straight out of IDLE; any later acknowledge is either
  // a miss or a closed-bank access, told apart by what was seen in IDLE.
  always_ff @(posedge sys_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      lat_miss  <= 1'b0;
      stat_hit  <= 16'd0;
      stat_miss <= 16'd0;
    end else begin
      if (state == IDLE) lat_miss <= open_q[cur_bank] && !hit;
      if (go_rw && (state == IDLE) && (stat_hit != 16'hFFFF))
        stat_hit <= stat_hit + 16'd1;
      if (go_rw && (state != IDLE) && lat_miss && (stat_miss != 16'hFFFF))
        stat_miss <= stat_miss + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hpdmc_rowctl.sv
// Self-checking bench for hpdmc_rowctl: directed scenarios then random accesses
// scored against a per-bank open-row model with closed-form command timing.
module tb_hpdmc_rowctl;
  localparam int ROW_W = 13;
  localparam int COL_W = 10;

  logic       sys_clk = 1'b0;
  logic       sdram_rst_n;
  logic [2:0] tim_rp, tim_rcd;
  logic [3:0] precharge_safe;
  logic       close_all;
  logic       close_done;
`ifdef HPDMC_ROWCTL_PERF_EN
  logic [15:0] stat_hit, stat_miss;
`endif

  hpdmc_rowctl_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

  hpdmc_rowctl #(.ROW_W(ROW_W), .COL_W(COL_W)) dut (
    .sys_clk        (sys_clk),
    .sdram_rst_n    (sdram_rst_n),
    .tim_rp         (tim_rp),
    .tim_rcd        (tim_rcd),
    .precharge_safe (precharge_safe),
    .close_all      (close_all),
    .close_done     (close_done),
`ifdef HPDMC_ROWCTL_PERF_EN
    .stat_hit       (stat_hit),
    .stat_miss      (stat_miss),
`endif
    .bus            (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: which row each bank holds open, and hit/miss tallies.
  bit mopen [4];
  int mrow  [4];
  int mhits = 0;
  int mmiss = 0;

  function automatic logic [31:0] pack(input logic stb, input logic [1:0] op,
                                       input logic [1:0] bank, input logic [ROW_W-1:0] addr,
                                       input logic ack, input logic [3:0] rd,
                                       input logic [3:0] wr, input logic done);
    return {4'b0, stb, op, bank, addr, ack, rd, wr, done};
  endfunction

  // Command fields only carry meaning while cmd_stb is high.
  function automatic logic [31:0] observe();
    if (bus.cmd_stb === 1'b1)
      return pack(1'b1, bus.cmd_op, bus.cmd_bank, bus.cmd_addr,
                  bus.req_ack, bus.read, bus.write, close_done);
    return pack(bus.cmd_stb, 2'd0, 2'd0, '0, bus.req_ack, bus.read, bus.write, close_done);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one access at the current negedge (cycle N) and check every cycle
  // up to its READ/WRITE, then one idle cycle.
  task automatic applyStimulus(input int bank, input int row, input int col,
                               input bit we, input int safe_lo);
    int rp, rcd, t_pre, t_act, t_rw;
    bit hit, closed;
    logic [31:0] exp;
    rp     = (tim_rp  == 3'd0) ? 1 : int'(tim_rp);
    rcd    = (tim_rcd == 3'd0) ? 1 : int'(tim_rcd);
    hit    = mopen[bank] && (mrow[bank] == row);
    closed = !mopen[bank];
    t_pre  = -1;
    t_act  = -1;
    if (hit) begin
      t_rw = 1;
    end else if (closed) begin
      t_act = 1;
      t_rw  = 1 + rcd;
    end else begin
      t_pre = safe_lo + 1;
      t_act = t_pre + rp;
      t_rw  = t_act + rcd;
    end

    bus.req_stb    = 1'b1;
    bus.req_we     = we;
    bus.req_bank   = 2'(bank);
    bus.req_row    = ROW_W'(row);
    bus.req_col    = COL_W'(col);
    precharge_safe = 4'hF;
    if (safe_lo > 0) precharge_safe[bank] = 1'b0;

    for (int k = 1; k <= t_rw; k++) begin
      @(negedge sys_clk);
      exp = pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0);
      if (k == t_pre) exp = pack(1'b1, 2'd3, 2'(bank), '0, 1'b0, 4'd0, 4'd0, 1'b0);
      if (k == t_act) exp = pack(1'b1, 2'd0, 2'(bank), ROW_W'(row), 1'b0, 4'd0, 4'd0, 1'b0);
      if (k == t_rw)
        exp = pack(1'b1, we ? 2'd2 : 2'd1, 2'(bank), ROW_W'(col), 1'b1,
                   we ? 4'd0 : 4'(1 << bank), we ? 4'(1 << bank) : 4'd0, 1'b0);
      checkOutput($sformatf("access b%0d r%0d k%0d", bank, row, k), observe(), exp);
      // Pending-request fields must be ignored once latched.
      bus.req_we   = 1'($urandom);
      bus.req_bank = 2'($urandom);
      bus.req_row  = ROW_W'($urandom);
      bus.req_col  = COL_W'($urandom);
      precharge_safe = 4'hF;
      if (k < safe_lo) precharge_safe[bank] = 1'b0;
    end
    bus.req_stb    = 1'b0;
    precharge_safe = 4'hF;
    if (hit && mhits < 65535) mhits++;
    if (!hit && !closed && mmiss < 65535) mmiss++;
    mopen[bank] = 1'b1;
    mrow[bank]  = row;
    @(negedge sys_clk);
    checkOutput("idle after ack", observe(), pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0));
  endtask

  // close_all with one bank's precharge_safe held low for low_len cycles.
  task automatic applyCloseAll(input int low_bank, input int low_len);
    int s, e;
    bit any_open;
    logic [ROW_W-1:0] pre_all;
    logic [31:0] exp;
    any_open = mopen[0] || mopen[1] || mopen[2] || mopen[3];
    s = (mopen[low_bank] && low_len > 1) ? low_len : 1;
    e = s + 1;
    pre_all = '0;
    pre_all[10] = 1'b1;

    close_all      = 1'b1;
    precharge_safe = 4'hF;
    if (low_len > 0) precharge_safe[low_bank] = 1'b0;
    for (int k = 1; k <= e; k++) begin
      @(negedge sys_clk);
      exp = pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0);
      if (k == e)
        exp = pack(any_open, any_open ? 2'd3 : 2'd0, 2'd0, any_open ? pre_all : '0,
                   1'b0, 4'd0, 4'd0, 1'b1);
      checkOutput($sformatf("close lb%0d len%0d k%0d", low_bank, low_len, k), observe(), exp);
      precharge_safe = 4'hF;
      if (k < low_len) precharge_safe[low_bank] = 1'b0;
    end
    close_all      = 1'b0;
    precharge_safe = 4'hF;
    for (int b = 0; b < 4; b++) mopen[b] = 1'b0;
    @(negedge sys_clk);
    checkOutput("idle after close", observe(), pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0));
  endtask

  initial begin
    sdram_rst_n    = 1'b0;
    tim_rp         = 3'd3;
    tim_rcd        = 3'd2;
    precharge_safe = 4'hF;
    close_all      = 1'b0;
    bus.req_stb    = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_bank   = 2'd0;
    bus.req_row    = '0;
    bus.req_col    = '0;
    for (int b = 0; b < 4; b++) begin
      mopen[b] = 1'b0;
      mrow[b]  = 0;
    end

    repeat (3) @(negedge sys_clk);
    checkOutput("in reset", observe(), pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0));
    sdram_rst_n = 1'b1;
    @(negedge sys_clk);
    checkOutput("after reset", observe(), pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0));

    $display("[TB] closed-bank read, row hit write, row miss with late safe");
    applyStimulus(0, 5, 3, 1'b0, 0);
    applyStimulus(0, 5, 4, 1'b1, 0);
    applyStimulus(0, 9, 7, 1'b0, 3);

    $display("[TB] close_all blocked by bank 2");
    applyStimulus(2, 1, 1, 1'b0, 0);
    applyCloseAll(2, 3);
    applyStimulus(2, 1, 1, 1'b0, 0);
    applyCloseAll(1, 0);
    applyCloseAll(0, 0);

    $display("[TB] reset during TRCD");
    tim_rcd      = 3'd5;
    bus.req_stb  = 1'b1;
    bus.req_we   = 1'b0;
    bus.req_bank = 2'd1;
    bus.req_row  = ROW_W'(7);
    bus.req_col  = COL_W'(2);
    @(negedge sys_clk);
    checkOutput("rst seq act", observe(), pack(1'b1, 2'd0, 2'd1, ROW_W'(7), 1'b0, 4'd0, 4'd0, 1'b0));
    @(negedge sys_clk);
    sdram_rst_n = 1'b0;
    #1;
    checkOutput("rst mid trcd", observe(), pack(1'b0, 2'd0, 2'd0, '0, 1'b0, 4'd0, 4'd0, 1'b0));
    @(negedge sys_clk);
    bus.req_stb = 1'b0;
    sdram_rst_n = 1'b1;
    for (int b = 0; b < 4; b++) mopen[b] = 1'b0;
    mhits = 0;
    mmiss = 0;
    @(negedge sys_clk);
    applyStimulus(1, 7, 2, 1'b0, 0);

    $display("[TB] random accesses");
    for (int i = 0; i < 200; i++) begin
      tim_rp  = 3'($urandom_range(0, 7));
      tim_rcd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0)
        applyCloseAll(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      else
        applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 3)));
    end

`ifdef HPDMC_ROWCTL_PERF_EN
    checkOutput("stat_hit", {16'd0, stat_hit}, 32'(mhits));
    checkOutput("stat_miss", {16'd0, stat_miss}, 32'(mmiss));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
